output_drain: RTL and testbench

- Sits directly downstream of the systolic array's output coordinator.
- Captures the per-PE finished accumulator values, tagged with absolute (row, col), into one-entry holding slots, one slot per PE.
- Serialises them by round-robin arbitration onto a single valid/ready write port into the output matrix SRAM.
- Filters out-of-range coordinates, counts completed writes, signals done, and requests an upstream stall when slots back up.

---
 rtl/output_drain.sv | 213 +++++++++++++++++++++
 tb/tb_output_drain.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_drain.sv
// Output drain: captures finished PE results into one-entry slots and serialises
// them round-robin onto a single valid/ready write port into the result SRAM.
module output_drain #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int MAX_N        = 16,
    parameter int N_BITS       = $clog2(MAX_N + 1),
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = $clog2(MAX_N * MAX_N),
    parameter int STALL_THRESH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] mat_size,
    input  logic              pe_valid [ROWS*COLS],
    input  logic [N_BITS-1:0] pe_row   [ROWS*COLS],
    input  logic [N_BITS-1:0] pe_col   [ROWS*COLS],
    input  logic [DATA_W-1:0] pe_data  [ROWS*COLS],
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              stall_req,
    output logic              busy,
    output logic              done,
    output logic              overflow_err
);

    localparam int NS    = ROWS * COLS;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam int OCC_W = $clog2(NS + 1);
    localparam int CNT_W = $clog2(MAX_N * MAX_N + 1);

    function automatic logic [ADDR_W-1:0] lin_addr(
        input logic [N_BITS-1:0] row,
        input logic [N_BITS-1:0] col,
        input logic [N_BITS-1:0] n
    );
        return ADDR_W'(row) * ADDR_W'(n) + ADDR_W'(col);
    endfunction

    // Control state
    logic [N_BITS-1:0] n_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic              stall_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  ptr_q;

    // Slot stage (p0) and output register stage (p1)
    logic              vld_p0  [NS];
    logic [ADDR_W-1:0] addr_p0 [NS];
    logic [DATA_W-1:0] data_p0 [NS];
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;

    // Combinational helpers
    logic              cap        [NS];
    logic [ADDR_W-1:0] cap_addr   [NS];
    logic              slot_load  [NS];
    logic              vld_p0_nxt [NS];
    logic              complete;
    logic              out_free;
    logic              grant_any;
    logic              take;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  ptr_nxt;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic              ovf_set;
    logic [OCC_W-1:0]  occ_nxt;
    logic [CNT_W-1:0]  target;
    int                rr;

    // Stage 0: range filter and linear address per PE
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            cap[k]      = pe_valid[k] && (pe_row[k] < n_q) && (pe_col[k] < n_q);
            cap_addr[k] = lin_addr(pe_row[k], pe_col[k], n_q);
        end
    end

    // A slot receiving a result this cycle is also a candidate, so a lone
    // result can bypass its slot and reach the write port one cycle later.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr        = 0;
        for (int k = 0; k < NS; k++) begin
            rr = (int'(ptr_q) + k) % NS;
            if (!grant_any && (vld_p0[rr] || cap[rr])) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(rr);
            end
        end
    end

    always_comb begin
        complete   = vld_p1 && wr_ready;
        out_free   = !vld_p1 || wr_ready;
        take       = out_free && grant_any;
        ptr_nxt    = IDX_W'((int'(grant_idx) + 1) % NS);
        grant_addr = vld_p0[grant_idx] ? addr_p0[grant_idx] : cap_addr[grant_idx];
        grant_data = vld_p0[grant_idx] ? data_p0[grant_idx] : pe_data[grant_idx];
        target     = CNT_W'(n_q) * CNT_W'(n_q);
    end

    // Slot occupancy after this cycle's drain and capture
    always_comb begin
        ovf_set = 1'b0;
        occ_nxt = '0;
        for (int k = 0; k < NS; k++) begin
            slot_load[k]  = 1'b0;
            vld_p0_nxt[k] = vld_p0[k];
            if (take && (grant_idx == IDX_W'(k))) begin
                // Drained: refill only when an older value was the one granted
                slot_load[k]  = cap[k] && vld_p0[k];
                vld_p0_nxt[k] = slot_load[k];
            end else if (cap[k]) begin
                if (vld_p0[k]) begin
                    ovf_set = 1'b1;
                end else begin
                    slot_load[k]  = 1'b1;
                    vld_p0_nxt[k] = 1'b1;
                end
            end
            occ_nxt = occ_nxt + OCC_W'(vld_p0_nxt[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NS; k++) begin
                vld_p0[k] <= 1'b0;
            end
            stall_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                vld_p0[k] <= vld_p0_nxt[k];
            end
            stall_q <= (int'(occ_nxt) > STALL_THRESH);
            if (take) begin
                ptr_q <= ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (slot_load[k]) begin
                addr_p0[k] <= cap_addr[k];
                data_p0[k] <= pe_data[k];
            end
        end
    end

    // Stage 1: output register, holds stable while the SRAM back-pressures
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else if (take) begin
            vld_p1  <= 1'b1;
            addr_p1 <= grant_addr;
            data_p1 <= grant_data;
        end else if (complete) begin
            vld_p1  <= 1'b0;
        end
    end

    // Matrix bookkeeping: completion counter, done, sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                busy_q <= 1'b1;
                n_q    <= mat_size;
                cnt_q  <= '0;
            end else if (busy_q && complete) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q + CNT_W'(1) == target) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (start) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign wr_en        = vld_p1;
    assign wr_addr      = addr_p1;
    assign wr_data      = data_p1;
    assign stall_req    = stall_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_output_drain.sv
// Scoreboard bench for output_drain: expected writes are queued as results are
// driven and popped as the write port completes them.
module tb_output_drain;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int NS     = ROWS * COLS;
    localparam int MAX_N  = 16;
    localparam int N_BITS = 5;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [N_BITS-1:0] mat_size;
    logic              pe_valid [NS];
    logic [N_BITS-1:0] pe_row   [NS];
    logic [N_BITS-1:0] pe_col   [NS];
    logic [DATA_W-1:0] pe_data  [NS];
    logic              wr_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              stall_req;
    logic              busy;
    logic              done;
    logic              overflow_err;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t sb [$];
    wr_t exp_wr;
    int  n_tests  = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  wr_cnt   = 0;
    int  cur_n    = 0;
    int  base_done;
    int  base_wr;

    output_drain #(
        .ROWS(ROWS), .COLS(COLS), .MAX_N(MAX_N), .N_BITS(N_BITS),
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_THRESH(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mat_size(mat_size),
        .pe_valid(pe_valid), .pe_row(pe_row), .pe_col(pe_col), .pe_data(pe_data),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .stall_req(stall_req), .busy(busy), .done(done), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wr_en && wr_ready) begin
            wr_cnt++;
            chk("wr_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                exp_wr = sb.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(exp_wr.addr));
                chk("wr_data", 64'(wr_data), 64'(exp_wr.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pe();
        for (int k = 0; k < NS; k++) pe_valid[k] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        clear_pe();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        mat_size = N_BITS'(n);
        cur_n    = n;
        step();
        start    = 1'b0;
    endtask

    task automatic fire(input int k, input int r, input int c, input logic [DATA_W-1:0] d,
                        input bit expect_wr);
        pe_valid[k] = 1'b1;
        pe_row[k]   = N_BITS'(r);
        pe_col[k]   = N_BITS'(c);
        pe_data[k]  = d;
        if (expect_wr && r < cur_n && c < cur_n)
            sb.push_back({ADDR_W'(r * cur_n + c), d});
    endtask

    task automatic fire_block(input int r0, input int c0, input logic [DATA_W-1:0] d0);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                fire(i * COLS + j, r0 + i, c0 + j, d0 + DATA_W'(i * COLS + j), 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((sb.size() != 0 || wr_en) && t < 100) begin
            step();
            t++;
        end
        chk(tag, 64'(t < 100), 64'(1));
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        mat_size = '0;
        wr_ready = 1'b1;
        for (int k = 0; k < NS; k++) begin
            pe_valid[k] = 1'b0;
            pe_row[k]   = '0;
            pe_col[k]   = '0;
            pe_data[k]  = '0;
        end

        // Reset state
        do_reset();
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_stall", 64'(stall_req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ovf", 64'(overflow_err), 64'(0));

        // Single result, one-cycle latency
        do_start(4);
        chk("t1_busy", 64'(busy), 64'(1));
        fire(0, 1, 2, 32'hDEAD, 1'b1);
        step();
        clear_pe();
        chk("t1_wr_en", 64'(wr_en), 64'(1));
        chk("t1_wr_addr", 64'(wr_addr), 64'(6));
        chk("t1_wr_data", 64'(wr_data), 64'(32'hDEAD));
        step();
        chk("t1_wr_en_off", 64'(wr_en), 64'(0));

        // Full 4x4 block, stall and done
        do_reset();
        do_start(4);
        base_done = done_cnt;
        wr_ready  = 1'b1;
        fire_block(0, 0, 32'h1000);
        step();
        clear_pe();
        for (int k = 0; k <= 18; k++) begin
            chk("t2_stall", 64'(stall_req), 64'((15 - k) > 8));
            chk("t2_done", 64'(done), 64'(k == 16));
            chk("t2_busy", 64'(busy), 64'(k < 16));
            step();
        end
        chk("t2_done_pulses", 64'(done_cnt - base_done), 64'(1));
        chk("t2_sb_empty", 64'(sb.size()), 64'(0));

        // N=5 built from four blocks, last one mostly out of range
        do_reset();
        do_start(5);
        base_done = done_cnt;
        fire_block(0, 0, 32'h2000);
        step();
        clear_pe();
        wait_drain("t3_drain_a");
        fire_block(0, 4, 32'h3000);
        step();
        clear_pe();
        wait_drain("t3_drain_b");
        fire_block(4, 0, 32'h4000);
        step();
        clear_pe();
        wait_drain("t3_drain_c");
        chk("t3_no_early_done", 64'(done_cnt - base_done), 64'(0));
        chk("t3_busy_mid", 64'(busy), 64'(1));
        base_wr = wr_cnt;
        fire_block(4, 4, 32'h5000);
        step();
        clear_pe();
        wait_drain("t3_drain_d");
        chk("t3_one_write", 64'(wr_cnt - base_wr), 64'(1));
        chk("t3_done_pulses", 64'(done_cnt - base_done), 64'(1));
        chk("t3_busy_end", 64'(busy), 64'(0));

        // Back-pressure hold and slot overflow
        do_reset();
        do_start(4);
        wr_ready = 1'b0;
        base_wr  = wr_cnt;
        fire(0, 0, 1, 32'h111, 1'b1);
        step();
        clear_pe();
        chk("t4_wr_en", 64'(wr_en), 64'(1));
        chk("t4_hold_addr0", 64'(wr_addr), 64'(1));
        fire(3, 2, 3, 32'hAAA, 1'b1);
        step();
        clear_pe();
        chk("t4_ovf_before", 64'(overflow_err), 64'(0));
        fire(3, 3, 0, 32'hBBB, 1'b0);
        step();
        clear_pe();
        chk("t4_ovf_set", 64'(overflow_err), 64'(1));
        for (int k = 0; k < 3; k++) begin
            chk("t4_hold_addr", 64'(wr_addr), 64'(1));
            chk("t4_hold_data", 64'(wr_data), 64'(32'h111));
            chk("t4_hold_en", 64'(wr_en), 64'(1));
            if (k < 2) step();
        end
        wr_ready = 1'b1;
        step();
        chk("t4_next_addr", 64'(wr_addr), 64'(11));
        chk("t4_next_data", 64'(wr_data), 64'(32'hAAA));
        step();
        chk("t4_idle", 64'(wr_en), 64'(0));
        chk("t4_write_count", 64'(wr_cnt - base_wr), 64'(2));
        chk("t4_ovf_sticky", 64'(overflow_err), 64'(1));
        chk("t4_sb_empty", 64'(sb.size()), 64'(0));
        do_start(4);
        chk("t4_ovf_clear", 64'(overflow_err), 64'(0));

        // Reset while slots are backed up
        do_reset();
        do_start(4);
        wr_ready = 1'b0;
        for (int k = 0; k < 10; k++) fire(k, k / COLS, k % COLS, 32'h6000 + DATA_W'(k), 1'b0);
        step();
        clear_pe();
        chk("t5_stall_pre", 64'(stall_req), 64'(1));
        chk("t5_wr_en_pre", 64'(wr_en), 64'(1));
        reset = 1'b1;
        step();
        chk("t5_wr_en", 64'(wr_en), 64'(0));
        chk("t5_stall", 64'(stall_req), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        reset    = 1'b0;
        wr_ready = 1'b1;
        base_wr  = wr_cnt;
        repeat (20) step();
        chk("t5_no_writes", 64'(wr_cnt - base_wr), 64'(0));
        chk("t5_ovf", 64'(overflow_err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
